// File: rtl/pkt_receiver_mc.sv
// Generic synchronous FIFO with power-of-two depth, shared by the receiver buffers.
// Latency: a word written at edge N sits at the head from cycle N+1.
// Backpressure: full refuses writes; a read of an empty FIFO is ignored.
module pkt_receiver_mc_fifo #(
   parameter int W  = 8,
   parameter int AW = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_vld,
   input  logic [W-1:0] wr_dat,
   input  logic         rd_rdy,
   output logic [W-1:0] rd_dat,
   output logic         full,
   output logic         empty
);
   logic [W-1:0]  mem [2**AW];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;
   logic          do_wr;
   logic          do_rd;

   assign full   = cnt[AW];
   assign empty  = (cnt == '0);
   assign do_wr  = wr_vld && !full;
   assign do_rd  = rd_rdy && !empty;
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_dat;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
         if (do_wr && !do_rd)      cnt <= cnt + 1'b1;
         else if (!do_wr && do_rd) cnt <= cnt - 1'b1;
      end
   end
endmodule

// Message receiver: validates notifications, issues read requests, re-frames payload with metadata.
// Latency: notification head to read request 1 cycle; payload head to pkt_tx 0 cycles (FIFO heads).
// Backpressure: input TREADY = FIFO not full; requests throttled by MAX_OUTST; pkt_tx holds while stalled.
module pkt_receiver_mc #(
   parameter int DATA_W    = 512,
   parameter int META_W    = 88,
   parameter int MAX_LEN   = 4096,
   parameter int MAX_OUTST = 16,
   parameter int NOTIF_AW  = 5,
   parameter int PAY_AW    = 7,
   parameter int META_AW   = 7
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [META_W-1:0]                    s_axis_notifications_TDATA,
   input  logic                                 s_axis_notifications_TVALID,
   output logic                                 s_axis_notifications_TREADY,
   input  logic [DATA_W:0]                      s_axis_rx_data_TDATA,
   input  logic                                 s_axis_rx_data_TVALID,
   output logic                                 s_axis_rx_data_TREADY,
   output logic [31:0]                          m_axis_read_package_TDATA,
   output logic                                 m_axis_read_package_TVALID,
   input  logic                                 m_axis_read_package_TREADY,
   output logic [META_W+DATA_W:0]               pkt_tx_TDATA,
   output logic                                 pkt_tx_TVALID,
   input  logic                                 pkt_tx_TREADY,
   output logic [31:0]                          drop_cnt,
   output logic [31:0]                          tlast_err_cnt,
   output logic [$clog2(MAX_OUTST+1)-1:0]       outstanding
);
   localparam int               OUT_W   = $clog2(MAX_OUTST+1);
   localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTST);
   localparam logic [31:0]      BEAT_B  = 32'(DATA_W / 8);

   logic [META_W-1:0] notif_head;
   logic [META_W-1:0] meta_head;
   logic [DATA_W:0]   pay_head;
   logic notif_full, notif_empty, pay_full, pay_empty, meta_full, meta_empty;
   logic [31:0] head_len, meta_len, meta_beats, bcnt;
   logic head_bad, drop, rd_hs, tx_hs, tlast_calc, out_inc, out_dec;

   assign s_axis_notifications_TREADY = rst_n && !notif_full;
   assign s_axis_rx_data_TREADY       = rst_n && !pay_full;

   // Head classification: anything that is not a whole number of beats within MAX_LEN is dropped.
   assign head_len = {16'd0, notif_head[31:16]};
   assign head_bad = (head_len == 32'd0) || ((head_len % BEAT_B) != 32'd0) ||
                     (head_len > 32'(MAX_LEN));
   assign drop     = rst_n && !notif_empty && head_bad;

   assign m_axis_read_package_TVALID = rst_n && !notif_empty && !head_bad && !meta_full &&
                                       (outstanding < OUT_MAX);
   assign m_axis_read_package_TDATA  = notif_head[31:0];
   assign rd_hs = m_axis_read_package_TVALID && m_axis_read_package_TREADY;

   assign meta_len   = {16'd0, meta_head[31:16]};
   assign meta_beats = meta_len / BEAT_B;
   assign tlast_calc = (bcnt == meta_beats - 32'd1);

   assign pkt_tx_TVALID = rst_n && !pay_empty && !meta_empty;
   assign pkt_tx_TDATA  = {meta_head, tlast_calc, pay_head[DATA_W-1:0]};
   assign tx_hs         = pkt_tx_TVALID && pkt_tx_TREADY;

   assign out_inc = rd_hs;
   assign out_dec = tx_hs && tlast_calc && (outstanding != '0);

   pkt_receiver_mc_fifo #(.W(META_W), .AW(NOTIF_AW)) u_notif_fifo (
      .clk(clk), .rst_n(rst_n),
      .wr_vld(s_axis_notifications_TVALID && s_axis_notifications_TREADY),
      .wr_dat(s_axis_notifications_TDATA),
      .rd_rdy(drop || rd_hs), .rd_dat(notif_head),
      .full(notif_full), .empty(notif_empty)
   );

   pkt_receiver_mc_fifo #(.W(DATA_W+1), .AW(PAY_AW)) u_pay_fifo (
      .clk(clk), .rst_n(rst_n),
      .wr_vld(s_axis_rx_data_TVALID && s_axis_rx_data_TREADY),
      .wr_dat(s_axis_rx_data_TDATA),
      .rd_rdy(tx_hs), .rd_dat(pay_head),
      .full(pay_full), .empty(pay_empty)
   );

   pkt_receiver_mc_fifo #(.W(META_W), .AW(META_AW)) u_meta_fifo (
      .clk(clk), .rst_n(rst_n),
      .wr_vld(rd_hs), .wr_dat(notif_head),
      .rd_rdy(tx_hs && tlast_calc), .rd_dat(meta_head),
      .full(meta_full), .empty(meta_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bcnt          <= '0;
         outstanding   <= '0;
         drop_cnt      <= '0;
         tlast_err_cnt <= '0;
      end else begin
         if (tx_hs) bcnt <= tlast_calc ? 32'd0 : bcnt + 32'd1;
         if (drop && drop_cnt != 32'hFFFF_FFFF) drop_cnt <= drop_cnt + 32'd1;
         if (tx_hs && (pay_head[DATA_W] != tlast_calc) && tlast_err_cnt != 32'hFFFF_FFFF)
            tlast_err_cnt <= tlast_err_cnt + 32'd1;
         if (out_inc && !out_dec)      outstanding <= outstanding + 1'b1;
         else if (out_dec && !out_inc) outstanding <= outstanding - 1'b1;
      end
   end
endmodule

// File: tb/tb_pkt_receiver_mc.sv
// Directed bench for pkt_receiver_mc with read-request and pkt_tx scoreboards.
`timescale 1ns/1ps
module tb_pkt_receiver_mc;
   localparam int DATA_W    = 512;
   localparam int META_W    = 88;
   localparam int MAX_LEN   = 4096;
   localparam int MAX_OUTST = 16;
   localparam int TX_W      = META_W + DATA_W + 1;
   localparam int OUT_W     = $clog2(MAX_OUTST+1);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [META_W-1:0] notif_dat = '0;
   logic              notif_vld = 1'b0;
   logic              notif_rdy;
   logic [DATA_W:0]   rx_dat = '0;
   logic              rx_vld = 1'b0;
   logic              rx_rdy;
   logic [31:0]       rd_dat;
   logic              rd_vld;
   logic              rd_rdy = 1'b1;
   logic [TX_W-1:0]   tx_dat;
   logic              tx_vld;
   logic              tx_rdy = 1'b1;
   logic [31:0]       drop_cnt;
   logic [31:0]       tlast_err_cnt;
   logic [OUT_W-1:0]  outstanding;

   always #5 clk = ~clk;

   pkt_receiver_mc #(
      .DATA_W(DATA_W), .META_W(META_W), .MAX_LEN(MAX_LEN), .MAX_OUTST(MAX_OUTST),
      .NOTIF_AW(5), .PAY_AW(7), .META_AW(7)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_notifications_TDATA(notif_dat), .s_axis_notifications_TVALID(notif_vld),
      .s_axis_notifications_TREADY(notif_rdy),
      .s_axis_rx_data_TDATA(rx_dat), .s_axis_rx_data_TVALID(rx_vld), .s_axis_rx_data_TREADY(rx_rdy),
      .m_axis_read_package_TDATA(rd_dat), .m_axis_read_package_TVALID(rd_vld),
      .m_axis_read_package_TREADY(rd_rdy),
      .pkt_tx_TDATA(tx_dat), .pkt_tx_TVALID(tx_vld), .pkt_tx_TREADY(tx_rdy),
      .drop_cnt(drop_cnt), .tlast_err_cnt(tlast_err_cnt), .outstanding(outstanding)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0, rd_seen = 0, tx_seen = 0, last_rd_cyc = 0, last_tx_cyc = 0;
   logic [31:0]     exp_rd[$];
   logic [TX_W-1:0] exp_tx[$];

   task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fail_now(input string tag);
      checks++;
      failures++;
      $error("FAIL %s observed=event-missing-or-unexpected expected=scoreboard-order", tag);
   endtask

   always @(posedge clk) cyc++;

   // Read-request monitor: order check against exp_rd and hold-while-stalled.
   logic [31:0] rd_prev = '0;
   logic        rd_stall = 1'b0;
   always @(negedge clk) begin
      if (rst_n && rd_stall) begin
         chk("rd_hold_vld", 640'(rd_vld), 640'(1'b1));
         chk("rd_hold_dat", 640'(rd_dat), 640'(rd_prev));
      end
      rd_stall = rst_n && rd_vld && !rd_rdy;
      rd_prev  = rd_dat;
      if (rst_n && rd_vld && rd_rdy) begin
         rd_seen++;
         last_rd_cyc = cyc;
         if (exp_rd.size() == 0) fail_now("rd_unexpected");
         else chk("rd_req", 640'(rd_dat), 640'(exp_rd.pop_front()));
      end
   end

   // pkt_tx monitor: order check against exp_tx and hold-while-stalled.
   logic [TX_W-1:0] tx_prev = '0;
   logic            tx_stall = 1'b0;
   always @(negedge clk) begin
      if (rst_n && tx_stall) begin
         chk("tx_hold_vld", 640'(tx_vld), 640'(1'b1));
         chk("tx_hold_dat", 640'(tx_dat), 640'(tx_prev));
      end
      tx_stall = rst_n && tx_vld && !tx_rdy;
      tx_prev  = tx_dat;
      if (rst_n && tx_vld && tx_rdy) begin
         tx_seen++;
         last_tx_cyc = cyc;
         if (exp_tx.size() == 0) fail_now("tx_unexpected");
         else chk("tx_beat", 640'(tx_dat), 640'(exp_tx.pop_front()));
      end
   end

   function automatic logic [META_W-1:0] nw(input int tag, input logic [15:0] len,
                                             input logic [15:0] sess);
      return {(META_W-32)'(tag), len, sess};
   endfunction

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // Drivers are entered and left at posedge+1; handshake is judged at the preceding negedge.
   task automatic send_notif(input logic [META_W-1:0] w);
      int t;
      bit done;
      t = 0;
      done = 1'b0;
      notif_vld = 1'b1;
      notif_dat = w;
      while (!done && t < 1000) begin
         @(negedge clk);
         done = notif_rdy;
         t++;
         @(posedge clk); #1;
      end
      notif_vld = 1'b0;
      if (!done) fail_now("notif_timeout");
   endtask

   task automatic send_beat(input logic [DATA_W-1:0] d, input logic tl);
      int t;
      bit done;
      t = 0;
      done = 1'b0;
      rx_vld = 1'b1;
      rx_dat = {tl, d};
      while (!done && t < 1000) begin
         @(negedge clk);
         done = rx_rdy;
         t++;
         @(posedge clk); #1;
      end
      rx_vld = 1'b0;
      if (!done) fail_now("beat_timeout");
   endtask

   // Full message: expected tlast comes from beat position, input tlast from tl_mask.
   task automatic send_msg(input int tag, input int nbeats, input logic [15:0] sess,
                           input logic [31:0] tl_mask);
      logic [META_W-1:0] w;
      logic [DATA_W-1:0] d;
      w = nw(tag, 16'(nbeats*64), sess);
      exp_rd.push_back(w[31:0]);
      send_notif(w);
      for (int b = 0; b < nbeats; b++) begin
         d = rand_data();
         exp_tx.push_back({w, (b == nbeats-1), d});
         send_beat(d, tl_mask[b]);
      end
   endtask

   task automatic drain(input string tag, input int budget);
      int t;
      t = 0;
      while ((exp_tx.size() != 0 || exp_rd.size() != 0) && t < budget) begin
         @(negedge clk);
         t++;
      end
      if (exp_tx.size() != 0 || exp_rd.size() != 0) fail_now(tag);
      @(posedge clk); #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog observed=no-finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [META_W-1:0] w;
      logic [META_W-1:0] m3[MAX_OUTST+1];
      logic [DATA_W-1:0] d0, d1;
      int base, t, total5, base_tx, nb;
      bit done5;

      // Reset state and release.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_notif_rdy", 640'(notif_rdy), 640'(0));
      chk("rst_rx_rdy",    640'(rx_rdy),    640'(0));
      chk("rst_rd_vld",    640'(rd_vld),    640'(0));
      chk("rst_tx_vld",    640'(tx_vld),    640'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_notif_rdy", 640'(notif_rdy),   640'(1));
      chk("rel_rx_rdy",    640'(rx_rdy),      640'(1));
      chk("rel_outst",     640'(outstanding), 640'(0));
      chk("rel_drop",      640'(drop_cnt),    640'(0));
      chk("rel_tlerr",     640'(tlast_err_cnt), 640'(0));
      @(posedge clk); #1;

      // Basic 128-byte message for session 7.
      w = nw(32'h11, 16'd128, 16'h0007);
      exp_rd.push_back(32'h0080_0007);
      send_notif(w);
      repeat (3) @(posedge clk); #1;
      chk("t1_outst_1", 640'(outstanding), 640'(1));
      d0 = rand_data();
      d1 = rand_data();
      exp_tx.push_back({w, 1'b0, d0});
      exp_tx.push_back({w, 1'b1, d1});
      send_beat(d0, 1'b0);
      send_beat(d1, 1'b1);
      drain("t1_drain", 200);
      chk("t1_outst_0", 640'(outstanding),   640'(0));
      chk("t1_tlerr",   640'(tlast_err_cnt), 640'(0));
      chk("t1_drop",    640'(drop_cnt),      640'(0));

      // Invalid lengths are dropped without a request.
      base = rd_seen;
      send_notif(nw(32'h21, 16'd0,    16'h0001));
      send_notif(nw(32'h22, 16'd100,  16'h0002));
      send_notif(nw(32'h23, 16'd4160, 16'h0003));
      repeat (6) @(posedge clk); #1;
      chk("t2_drop",   640'(drop_cnt),       640'(3));
      chk("t2_no_rd",  640'(rd_seen - base), 640'(0));
      chk("t2_outst",  640'(outstanding),    640'(0));

      // Outstanding limit: MAX_OUTST+1 requests with no payload.
      base = rd_seen;
      for (int i = 0; i <= MAX_OUTST; i++) begin
         m3[i] = nw(100 + i, 16'd64, 16'(i));
         exp_rd.push_back(m3[i][31:0]);
         send_notif(m3[i]);
      end
      repeat (10) @(posedge clk); #1;
      chk("t3_rd_issued",  640'(rd_seen - base), 640'(MAX_OUTST));
      chk("t3_outst_max",  640'(outstanding),    640'(MAX_OUTST));
      chk("t3_rd_blocked", 640'(rd_vld),         640'(0));
      d0 = rand_data();
      exp_tx.push_back({m3[0], 1'b1, d0});
      send_beat(d0, 1'b1);
      t = 0;
      while (rd_seen != base + MAX_OUTST + 1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (rd_seen != base + MAX_OUTST + 1) fail_now("t3_next_rd_timeout");
      chk("t3_next_rd_cycle", 640'(last_rd_cyc - last_tx_cyc), 640'(1));
      @(posedge clk); #1;
      for (int i = 1; i <= MAX_OUTST; i++) begin
         d0 = rand_data();
         exp_tx.push_back({m3[i], 1'b1, d0});
         send_beat(d0, 1'b1);
      end
      drain("t3_drain", 500);
      chk("t3_outst_0", 640'(outstanding), 640'(0));

      // 192-byte message with input tlast on beat 2.
      send_msg(32'h41, 3, 16'h0041, 32'b010);
      drain("t4_drain", 200);
      chk("t4_tlerr", 640'(tlast_err_cnt), 640'(2));
      chk("t4_outst", 640'(outstanding),   640'(0));

      // 1000 messages under random sink backpressure.
      total5 = 0;
      base_tx = tx_seen;
      done5 = 1'b0;
      fork
         begin
            for (int m = 0; m < 1000; m++) begin
               nb = $urandom_range(1, 4);
               total5 += nb;
               send_msg(1000 + m, nb, 16'(m), 32'(1) << (nb - 1));
            end
            drain("t5_drain", 20000);
            done5 = 1'b1;
         end
         begin
            while (!done5) begin
               @(posedge clk); #1;
               tx_rdy = 1'($urandom_range(0, 1));
               rd_rdy = 1'($urandom_range(0, 1));
            end
         end
      join
      tx_rdy = 1'b1;
      rd_rdy = 1'b1;
      chk("t5_beats", 640'(tx_seen - base_tx), 640'(total5));
      chk("t5_tlerr", 640'(tlast_err_cnt),     640'(2));
      chk("t5_outst", 640'(outstanding),       640'(0));

      // Reset pulse in the middle of a 3-beat message.
      w = nw(32'h66, 16'd192, 16'h0006);
      exp_rd.push_back(w[31:0]);
      send_notif(w);
      d0 = rand_data();
      exp_tx.push_back({w, 1'b0, d0});
      send_beat(d0, 1'b0);
      drain("t6_pre_drain", 200);
      chk("t6_outst_pre", 640'(outstanding), 640'(1));
      tx_rdy = 1'b0;
      send_beat(rand_data(), 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6_rst_notif_rdy", 640'(notif_rdy), 640'(0));
      chk("t6_rst_rx_rdy",    640'(rx_rdy),    640'(0));
      chk("t6_rst_tx_vld",    640'(tx_vld),    640'(0));
      chk("t6_rst_rd_vld",    640'(rd_vld),    640'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_notif_rdy", 640'(notif_rdy),     640'(1));
      chk("t6_rx_rdy",    640'(rx_rdy),        640'(1));
      chk("t6_drop",      640'(drop_cnt),      640'(0));
      chk("t6_tlerr",     640'(tlast_err_cnt), 640'(0));
      chk("t6_outst",     640'(outstanding),   640'(0));
      chk("t6_tx_empty",  640'(tx_vld),        640'(0));
      @(posedge clk); #1;
      tx_rdy = 1'b1;
      w = nw(32'h77, 16'd64, 16'h0042);
      exp_rd.push_back(32'h0040_0042);
      send_notif(w);
      d0 = rand_data();
      exp_tx.push_back({w, 1'b1, d0});
      send_beat(d0, 1'b1);
      drain("t6_post_drain", 200);
      chk("t6_post_outst", 640'(outstanding),   640'(0));
      chk("t6_post_tlerr", 640'(tlast_err_cnt), 640'(0));

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/pkt_receiver_mc.md
PKT_RECEIVER_MC -- requirements
Module: pkt_receiver_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 512: payload beat width in bits; DATA_W/8 is the beat size in bytes (BEAT_B).
REQ-002 SHALL have parameter META_W, default 88: notification and metadata width.
REQ-003 SHALL have parameter MAX_LEN, default 4096: largest accepted message length in bytes.
REQ-004 SHALL have parameter MAX_OUTST, default 16: maximum number of issued read requests whose payload is not yet fully forwarded.
REQ-005 SHALL have parameters NOTIF_AW, default 5, PAY_AW, default 7, and META_AW, default 7: log2 depths of the notification, payload and metadata FIFOs.
REQ-006 SHALL have the following port: clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-007 SHALL have the following port: rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have the following ports: s_axis_notifications_TDATA, input, META_W bits; s_axis_notifications_TVALID, input, 1 bit; s_axis_notifications_TREADY, output, 1 bit. Bits [31:16] are the length in bytes; bits [15:0] are the session.
REQ-009 SHALL have the following ports: s_axis_rx_data_TDATA, input, DATA_W+1 bits, laid out as {tlast, data}; s_axis_rx_data_TVALID, input, 1 bit; s_axis_rx_data_TREADY, output, 1 bit.
REQ-010 SHALL have the following ports: m_axis_read_package_TDATA, output, 32 bits, equal to notification bits [31:0]; m_axis_read_package_TVALID, output, 1 bit; m_axis_read_package_TREADY, input, 1 bit.
REQ-011 SHALL have the following ports: pkt_tx_TDATA, output, META_W+DATA_W+1 bits, laid out as {meta, tlast, data}; pkt_tx_TVALID, output, 1 bit; pkt_tx_TREADY, input, 1 bit.
REQ-012 SHALL have the following status outputs: drop_cnt, output, 32 bits; tlast_err_cnt, output, 32 bits; outstanding, output, clog2(MAX_OUTST+1) bits.

Function
REQ-013 SHALL buffer notifications and payload in FIFOs of depth 2^NOTIF_AW and 2^PAY_AW. TREADY = not full. A word written in cycle N is visible at the FIFO head in cycle N+1. Any payload TVALID beat is accepted; there is no edge detection.
REQ-014 SHALL classify the notification at the FIFO head as invalid if len==0, len mod BEAT_B != 0, or len>MAX_LEN.
REQ-015 SHALL pop an invalid head in one cycle with no read request issued, and SHALL increment drop_cnt, saturating at 0xFFFFFFFF.
REQ-016 SHALL drive m_axis_read_package_TVALID for a valid head only when the metadata FIFO is not full and outstanding<MAX_OUTST.
REQ-017 SHALL, on a read-request handshake, in the same cycle pop the notification, push it to the metadata FIFO, and increment outstanding.
REQ-018 SHALL keep m_axis_read_package_TVALID and TDATA stable until TREADY is asserted.
REQ-019 SHALL drive pkt_tx_TVALID = payload head valid AND metadata head valid, and pkt_tx_TDATA = {metadata head, computed tlast, payload data}.
REQ-020 SHALL hold a beat counter bcnt. Computed tlast = (bcnt == len_head/BEAT_B - 1). bcnt increments on each pkt_tx handshake and clears to 0 on a handshake with computed tlast.
REQ-021 SHALL, on a pkt_tx handshake with computed tlast, pop the metadata FIFO and decrement outstanding.
REQ-022 SHALL increment tlast_err_cnt (saturating) on any pkt_tx handshake where the input tlast differs from the computed tlast; forwarding is unaffected.
REQ-023 SHALL leave outstanding unchanged on a simultaneous increment and decrement. outstanding SHALL never exceed MAX_OUTST or underflow; a decrement at 0 is ignored.
REQ-024 SHALL hold pkt_tx outputs stable while TVALID=1 and TREADY=0.
REQ-025 SHALL, when a message is exactly BEAT_B bytes, assert computed tlast on its first beat.
REQ-026 SHALL forward a full payload FIFO with the metadata FIFO empty without loss; it only stalls.

Reset
REQ-027 SHALL, when rst_n=0 at a clock edge, empty all FIFOs and set bcnt, outstanding, drop_cnt and tlast_err_cnt to 0. All TVALID outputs and s_axis TREADY outputs SHALL be 0 during reset.
REQ-028 SHALL discard any partially forwarded message when reset is asserted mid-message. After release, the first pkt_tx beat SHALL carry bcnt=0 semantics.
REQ-029 SHALL reach TREADY=1 on both input FIFOs in the first cycle after rst_n returns to 1.

Verification
REQ-030 SHALL cover: notification len=128 for session 0x0007, then 2 payload beats with the second beat's tlast=1, sink always ready -> read request 0x00800007, 2 pkt_tx beats with meta attached, computed tlast on beat 2, outstanding 1->0, no error counts.
REQ-031 SHALL cover: notifications with len=0, len=100 and len=4160 -> no read requests issued, drop_cnt=3.
REQ-032 SHALL cover: MAX_OUTST+1 valid notifications with no payload -> exactly MAX_OUTST requests issued; the next request is issued one cycle after the first message's final beat.
REQ-033 SHALL cover: len=192 with input tlast on beat 2 -> 3 beats forwarded, computed tlast on beat 3, tlast_err_cnt=2.
REQ-034 SHALL cover: pkt_tx_TREADY toggled randomly for 1000 messages -> in-order data, no duplicated or lost beats, outputs stable while stalled.
REQ-035 SHALL cover: rst_n pulsed low for 1 cycle mid-message -> counters 0, FIFOs empty, correct forwarding of a fresh len=64 message afterward.
